// File: rtl/demux_1to16_capture_pkg.sv
// Shared constants for the 1:16 serial demultiplexer/capture block.
package demux_1to16_capture_pkg;

  localparam int DEFAULT_LANES = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/demux_1to16_capture.sv
// Routes a serial bit stream onto registered lanes, either by external select
// or by an internal scan that assembles whole frames behind a valid/ready handshake.
module demux_1to16_capture
  import demux_1to16_capture_pkg::*;
#(
  parameter  int LANES = DEFAULT_LANES,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic             start,
  output logic [LANES-1:0] out,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic [SEL_W-1:0] scan_idx,
  output logic             overrun
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LANES - 1);

  logic [1:0]       state;
  logic [LANES-1:0] shadow;

  function automatic logic [LANES-1:0] insert_bit(input logic [LANES-1:0] word,
                                                  input logic [SEL_W-1:0] idx,
                                                  input logic             bit_val);
    logic [LANES-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    insert_bit = (word & ~onehot) | ({LANES{bit_val}} & onehot);
  endfunction

  assign busy = (state != ST_IDLE);

  // Auto-scan fills a hidden shadow so partial frames never reach the lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      out         <= '0;
      shadow      <= '0;
      frame_valid <= 1'b0;
      scan_idx    <= '0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mode == MODE_ADDR) begin
            if (in_valid) out <= insert_bit(out, sel, in);
          end else if (mode == MODE_SCAN && start) begin
            state    <= ST_SCAN;
            scan_idx <= '0;
            overrun  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (in_valid) begin
            if (scan_idx == LAST_IDX) begin
              out         <= insert_bit(shadow, scan_idx, in);
              frame_valid <= 1'b1;
              scan_idx    <= '0;
              state       <= ST_HOLD;
            end else begin
              shadow   <= insert_bit(shadow, scan_idx, in);
              scan_idx <= scan_idx + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Any bit arriving here is dropped; only unacknowledged ones flag overrun.
          if (frame_ready) begin
            frame_valid <= 1'b0;
            if (start) begin
              state    <= ST_SCAN;
              scan_idx <= '0;
              overrun  <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (in_valid) begin
            overrun <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1to16_capture.sv
// Randomised self-checking bench for demux_1to16_capture against a word-level model.
module tb_demux_1to16_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        in_valid;
  logic [3:0]  sel;
  logic        mode;
  logic        start;
  logic [15:0] out;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;
  logic [3:0]  scan_idx;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_out;

  demux_1to16_capture dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .sel(sel),
    .mode(mode), .start(start), .out(out), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .scan_idx(scan_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    din = 1'b0; in_valid = 1'b0; sel = '0; start = 1'b0; frame_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 1'b0; idle_inputs();
    step(); step();
    checks++;
    if ({out, frame_valid, busy, scan_idx, overrun} !== 23'd0) begin
      failures++;
      $display("[TB] FAIL reset_state out=%h fv=%b busy=%b idx=%0d ovr=%b required all zero",
               out, frame_valid, busy, scan_idx, overrun);
    end
    rst = 1'b0;
    exp_out = '0;
    step();
  endtask

  task automatic test_addressed;
    logic [15:0] pattern;
    pattern = 16'hAAAA;
    mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i); din = pattern[i]; in_valid = 1'b1; start = 1'(i % 3 == 0);
      step();
      exp_out[i] = pattern[i];
    end
    idle_inputs();
    checks++;
    if (out !== 16'hAAAA || frame_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_aaaa out=%h fv=%b busy=%b required out=aaaa fv=0 busy=0",
               out, frame_valid, busy);
    end
    for (int n = 0; n < 40; n++) begin
      sel = 4'($urandom_range(0, 15));
      din = 1'($urandom);
      in_valid = 1'($urandom);
      start = 1'($urandom);
      step();
      if (in_valid) exp_out[sel] = din;
      checks++;
      if (out !== exp_out || frame_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL addr_random n=%0d out=%h fv=%b busy=%b required out=%h fv=0 busy=0",
                 n, out, frame_valid, busy, exp_out);
      end
    end
    idle_inputs();
  endtask

  // Streams one word LSB first while already in scan; gap inserts an idle cycle after each bit.
  task automatic scan_word(input logic [15:0] word, input bit gap, input string tag);
    logic [15:0] held;
    int collected;
    held = exp_out;
    collected = 0;
    for (int c = 0; c < (gap ? 31 : 16); c++) begin
      in_valid = gap ? 1'(c % 2 == 0) : 1'b1;
      din = in_valid ? word[collected] : 1'($urandom);
      sel = 4'($urandom); mode = 1'($urandom); start = 1'($urandom);
      frame_ready = 1'($urandom);
      step();
      if (in_valid) collected++;
      if (collected == 16) exp_out = word;
      checks++;
      if (out !== exp_out || frame_valid !== (collected == 16) || busy !== 1'b1
          || scan_idx !== 4'(collected % 16)) begin
        failures++;
        $display("[TB] FAIL %s c=%0d out=%h fv=%b busy=%b idx=%0d required out=%h fv=%b busy=1 idx=%0d",
                 tag, c, out, frame_valid, busy, scan_idx, collected == 16 ? word : held,
                 collected == 16, collected % 16);
      end
    end
    idle_inputs();
    mode = 1'b1;
  endtask

  task automatic begin_scan;
    mode = 1'b1; start = 1'b1; in_valid = 1'b1; din = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (busy !== 1'b1 || scan_idx !== 4'd0 || overrun !== 1'b0 || out !== exp_out) begin
      failures++;
      $display("[TB] FAIL scan_start busy=%b idx=%0d ovr=%b out=%h required busy=1 idx=0 ovr=0 out=%h",
               busy, scan_idx, overrun, out, exp_out);
    end
  endtask

  task automatic accept_frame;
    frame_ready = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || out !== exp_out) begin
      failures++;
      $display("[TB] FAIL accept fv=%b busy=%b out=%h required fv=0 busy=0 out=%h",
               frame_valid, busy, out, exp_out);
    end
  endtask

  task automatic test_auto_scan;
    exp_out = out;
    begin_scan();
    scan_word(16'h5A3C, 1'b0, "scan_5a3c");
    accept_frame();
    begin_scan();
    scan_word(16'($urandom), 1'b0, "scan_random");
    accept_frame();
  endtask

  task automatic test_gaps;
    begin_scan();
    scan_word(16'h5A3C, 1'b1, "gaps_5a3c");
    accept_frame();
    begin_scan();
    scan_word(16'($urandom), 1'b1, "gaps_random");
  endtask

  task automatic test_backpressure;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; din = 1'($urandom); frame_ready = 1'b0;
      step();
      checks++;
      if (overrun !== 1'b1 || out !== exp_out || frame_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL hold_overrun n=%0d ovr=%b out=%h fv=%b required ovr=1 out=%h fv=1",
                 n, overrun, out, frame_valid, exp_out);
      end
    end
    in_valid = 1'b0; frame_ready = 1'b1; start = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0 || scan_idx !== 4'd0) begin
      failures++;
      $display("[TB] FAIL hold_restart fv=%b busy=%b ovr=%b idx=%0d required fv=0 busy=1 ovr=0 idx=0",
               frame_valid, busy, overrun, scan_idx);
    end
    scan_word(16'($urandom), 1'b0, "bp_frame");
    in_valid = 1'b1; din = 1'b1; frame_ready = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0 || frame_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_ready_drop ovr=%b busy=%b fv=%b required ovr=0 busy=0 fv=0",
               overrun, busy, frame_valid);
    end
  endtask

  task automatic test_reset_mid_scan;
    begin_scan();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; din = 1'($urandom);
      step();
    end
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if ({out, frame_valid, busy, scan_idx, overrun} !== 23'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_scan out=%h fv=%b busy=%b idx=%0d ovr=%b required all zero",
               out, frame_valid, busy, scan_idx, overrun);
    end
    step();
    rst = 1'b0;
    exp_out = '0;
    step();
    begin_scan();
    scan_word(16'hFFFF, 1'b0, "post_reset_ffff");
  endtask

  task automatic test_back_to_back;
    logic [15:0] words [2];
    words[0] = 16'h0001;
    words[1] = 16'($urandom);
    for (int f = 0; f < 2; f++) begin
      frame_ready = 1'b1; start = 1'b1; in_valid = 1'b1; din = 1'b1; mode = 1'b0;
      step();
      idle_inputs();
      checks++;
      if (busy !== 1'b1 || frame_valid !== 1'b0 || overrun !== 1'b0 || out !== exp_out) begin
        failures++;
        $display("[TB] FAIL b2b_chain f=%0d busy=%b fv=%b ovr=%b out=%h required busy=1 fv=0 ovr=0 out=%h",
                 f, busy, frame_valid, overrun, out, exp_out);
      end
      scan_word(words[f], 1'b0, "b2b_frame");
    end
    accept_frame();
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_auto_scan();
    test_gaps();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1to16_capture.md
Name: demux_1to16_capture

Overview:
Inverse of the 16:1 mux path: takes a 1-bit stream and routes each bit to one of 16 registered output lanes, reassembling a 16-bit word. Two modes: addressed (external select chooses the lane per bit) and auto-scan (internal counter sweeps lanes 0..15 and emits a completed frame with valid/ready handshake). Sits on the receive side of a mux-driven serialised link.

Parameters:
LANES, 16, number of output lanes (power of 2, >=2)
SEL_W, $clog2(LANES), select/index width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in  input  1  serial data bit
in_valid  input  1  qualifies in
sel  input  SEL_W  lane select, addressed mode only
mode  input  1  0 = addressed, 1 = auto-scan; sampled only in IDLE
start  input  1  begins an auto-scan frame (mode=1, IDLE/HOLD only)
out  output  LANES  registered lane array; out[i] = last bit routed to lane i
frame_valid  output  1  auto-scan frame complete, out stable
frame_ready  input  1  consumer accepts frame
busy  output  1  high in SCAN or HOLD
scan_idx  output  SEL_W  next lane index written in SCAN
overrun  output  1  sticky: in_valid seen in HOLD (bit dropped)

Behaviour:
- Reset (async assert, sync-safe deassert on clk): out=0, frame_valid=0, busy=0, scan_idx=0, overrun=0, shadow=0, state=IDLE.
- FSM states: IDLE, SCAN, HOLD.
- IDLE, mode=0: in_valid=1 -> out[sel] <= in on next edge; other lanes hold. Latency 1 cycle. start ignored.
- IDLE, mode=1, start=1 -> SCAN, scan_idx=0, overrun cleared. in_valid in same cycle ignored (first capture next cycle).
- SCAN: each cycle with in_valid=1: shadow[scan_idx] <= in, scan_idx++. in_valid=0 cycles are gaps, nothing changes. sel, mode, start ignored.
- SCAN, in_valid=1 and scan_idx=LANES-1: out <= {in, shadow[LANES-2:0]}, frame_valid <= 1, scan_idx wraps to 0, -> HOLD. out updates only at frame completion in auto-scan (no partial frames visible).
- HOLD: frame_valid=1, out stable. frame_ready=1 -> frame_valid <= 0 next edge; if start=1 same cycle -> SCAN (overrun cleared), else -> IDLE.
- HOLD, in_valid=1 and frame_ready=0: bit dropped, overrun <= 1 (sticky until next accepted start or rst). in_valid together with frame_ready: dropped, no overrun.
- busy = (state != IDLE), combinational from state register.
- Reset mid-SCAN or mid-HOLD: immediate return to reset values; partial shadow discarded.
- Mode change mid-frame: no effect until back in IDLE.

Decomposition:
- Shared package: state enum constants (ST_IDLE=2'd0, ST_SCAN=2'd1, ST_HOLD=2'd2), MODE_ADDR=1'b0, MODE_SCAN=1'b1, default LANES.
- Single module; no sub-module needed. Lane write-enable decode (sel/scan_idx one-hot) may be a local function.

Test Plan:
- Addressed: mode=0, write bits of 16'hAAAA with sel=0..15, one per cycle -> out==16'hAAAA one cycle after last write; frame_valid stays 0, busy stays 0.
- Auto-scan: mode=1, start, then 16 consecutive valid bits of 16'h5A3C LSB first -> out==16'h5A3C and frame_valid=1 on edge after 16th bit; out unchanged (0) during the scan.
- Gaps: same as above with in_valid deasserted every other cycle -> identical out, frame_valid after 31 cycles of stream; scan_idx only advances on valid cycles.
- Backpressure: hold frame_ready=0, drive 3 valid bits in HOLD -> overrun=1, out unchanged; frame_ready=1 with start=1 -> frame_valid=0, SCAN, overrun=0.
- Reset mid-SCAN after 7 bits: rst pulse -> all outputs 0, state IDLE; new full frame 16'hFFFF captures correctly.
- Handshake chaining: frame_ready and start high in same HOLD cycle -> next frame 16'h0001 captured back-to-back, no lost bits, busy never drops.
